trig_updown_counter: RTL and testbench
======================================

Name: trig_updown_counter

Overview:
- Downstream consumer of the TriggerIn endpoint. It turns one-cycle trigger pulses into a programmable up/down counter with a fixed step, a bound, selectable terminal behaviour and pause/resume.
- A coherent snapshot is split into two 16-bit halves for a WireOut pair, so the host never reads a torn value.
- A terminal-count pulse is produced for a TriggerOut endpoint.
- Replaces the ad-hoc counter logic in board top levels; sits between okTriggerIn/okWireIn and okWireOut/okTriggerOut.

Parameters:
- WIDTH, 32, counter, load value and limit width (16..32; snapshot halves zero-extend the upper bits).
- STEP_W, 16, width of the step input.

Ports:
- sys_clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- trig  in  8  one-cycle pulses from TriggerIn (sys_clk domain): [0] clear, [1] up, [2] down, [3] load, [4] snapshot, [5] pause, [6] resume, [7] reserved/ignored.
- load_value  in  WIDTH  value written by the load trigger (from WireIn).
- step  in  STEP_W  increment/decrement amount; 0 is treated as 1.
- limit  in  WIDTH  upper bound (inclusive); the lower bound is 0.
- mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
- count  out  WIDTH  live counter value.
- snap_lo  out  16  snapshot[15:0].
- snap_hi  out  16  snapshot[31:16].
- term_pulse  out  1  one-cycle pulse on a terminal event.
- run_state  out  2  00 RUN, 01 PAUSED, 10 HALTED.
- term_count  out  16  terminal event tally (see Optional Feature).

Behaviour:
- Reset: count=0, snapshot=0, term_pulse=0, run_state=RUN, term_count=0.
- All outputs are registered. count reflects a trigger on the cycle after the pulse (1-cycle latency); term_pulse has the same latency.
- Per-cycle priority: reset > clear > load > up/down. Snapshot and pause/resume are evaluated in parallel with these.
- clear: count=0, state→RUN, no term_pulse.
- load: count=min(load_value, limit), state→RUN, no term_pulse.
- up and down in the same cycle: no count change, no term_pulse.
- Up (state RUN only), with sum = count+step computed at WIDTH+1 bits:
  - sum ≤ limit: count=sum.
  - Otherwise it is a terminal event. Wrap → count=0. Saturate → count=limit. One-shot → count=limit and state→HALTED.
- Down (state RUN only):
  - step ≤ count: count=count−step.
  - Otherwise it is a terminal event. Wrap → count=limit. Saturate → count=0. One-shot → count=0 and state→HALTED.
- Saturate: a terminal event fires on every further up/down pulse that stays clamped.
- If limit is lowered below count, the next up pulse is a terminal event. Down pulses behave normally.
- FSM:
  - RUN → PAUSED on pause. PAUSED → RUN on resume.
  - RUN → HALTED on a one-shot terminal event. HALTED exits only on clear, load or reset.
  - In PAUSED and HALTED, up/down are ignored.
  - pause and resume together: no state change.
  - pause/resume in HALTED: ignored.
- Snapshot: captures count as registered at the start of that cycle (pre-update). The snapshot is held until the next snapshot trigger or reset.
- snap_lo/snap_hi always come from the snapshot register, never from the live count.
- Reset asserted mid-operation overrides every trigger in that cycle.

Optional Feature:
- Macro: TRIG_UPDOWN_COUNTER_EVENT_CNT_EN.
- Defined: term_count increments on each term_pulse, saturates at 16'hFFFF and is cleared by reset or clear.
- Undefined: term_count is tied to 16'h0000 and no register is inferred. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - trigger bit index constants: TRIG_CLEAR=0, TRIG_UP=1, TRIG_DOWN=2, TRIG_LOAD=3, TRIG_SNAP=4, TRIG_PAUSE=5, TRIG_RESUME=6;
  - mode encodings: MODE_WRAP, MODE_SAT, MODE_ONESHOT;
  - run_state encodings.
- One natural sub-module, trig_counter_next. It is combinational: it computes next count and the terminal flag from count, step, limit, mode and direction. This lets the bound arithmetic be unit-tested alone.

Test Plan:
- Wrap up: limit=9, step=4, count=8, up pulse → count=0, term_pulse=1 for exactly one cycle one cycle later.
- Saturate down: count=3, step=5, mode=01, two down pulses → count=0 both times, two term_pulses.
- One-shot: limit=100, step=60, two up pulses → count=60 then 100 with run_state=HALTED. A third up is ignored; a load of 250 gives count=100 and run_state=RUN.
- Priority: clear+load+up in the same cycle → count=0. up+down together from 7 → stays 7. pause+resume together → state unchanged.
- Snapshot coherency: count=32'h0001_FFFF, snapshot and up (step=1) in the same cycle → snap_hi=16'h0001, snap_lo=16'hFFFF, count=32'h0002_0000.
- Reset mid-run: state PAUSED, count=55, term_count=3, reset with up pulse → all outputs 0, run_state=RUN. Repeat with the macro undefined and check term_count stays 0 throughout.

Source files
------------

// File: rtl/trig_updown_counter_pkg.sv
// trig_updown_counter_pkg: trigger bit indices, mode and run-state encodings shared by the counter block
package trig_updown_counter_pkg;
    localparam int TRIG_CLEAR  = 0;
    localparam int TRIG_UP     = 1;
    localparam int TRIG_DOWN   = 2;
    localparam int TRIG_LOAD   = 3;
    localparam int TRIG_SNAP   = 4;
    localparam int TRIG_PAUSE  = 5;
    localparam int TRIG_RESUME = 6;
    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;
    localparam logic [1:0] ST_RUN    = 2'b00;
    localparam logic [1:0] ST_PAUSED = 2'b01;
    localparam logic [1:0] ST_HALTED = 2'b10;
endpackage

// File: rtl/trig_counter_next.sv
// trig_counter_next: combinational next-count and terminal detection for one up or down step
module trig_counter_next
    import trig_updown_counter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STEP_W = 16
) (
    input  logic [WIDTH-1:0]  count,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    input  logic [1:0]        mode,
    input  logic              up,
    output logic [WIDTH-1:0]  next_count,
    output logic              term,
    output logic              halt
);
    logic [WIDTH:0] stp;
    logic [WIDTH:0] sum;
    logic           clamp;
    assign stp   = (step == '0) ? (WIDTH+1)'(1) : (WIDTH+1)'(step);
    assign sum   = {1'b0, count} + stp;
    assign clamp = (mode == MODE_SAT) || (mode == MODE_ONESHOT);
    assign term  = up ? (sum > {1'b0, limit}) : (stp > {1'b0, count});
    assign halt  = term && (mode == MODE_ONESHOT);
    // wrap sends an overflow to the opposite bound; saturate and one-shot clamp to the bound crossed
    always_comb begin
        next_count = up ? (term ? (clamp ? limit : '0) : sum[WIDTH-1:0])
                        : (term ? (clamp ? '0 : limit) : count - stp[WIDTH-1:0]);
    end
endmodule

// File: rtl/trig_updown_counter.sv
// trig_updown_counter: trigger-driven up/down counter with snapshot halves and terminal pulse.
// Define TRIG_UPDOWN_COUNTER_EVENT_CNT_EN to enable the saturating terminal event tally.
module trig_updown_counter
    import trig_updown_counter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STEP_W = 16
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic [7:0]        trig,
    input  logic [WIDTH-1:0]  load_value,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    input  logic [1:0]        mode,
    output logic [WIDTH-1:0]  count,
    output logic [15:0]       snap_lo,
    output logic [15:0]       snap_hi,
    output logic              term_pulse,
    output logic [1:0]        run_state,
    output logic [15:0]       term_count
);
    logic [31:0]      snapshot;
    logic [WIDTH-1:0] nxt;
    logic             term;
    logic             halt;
    logic             move;
    logic             event_hit;
    logic             unused_trig;
    assign unused_trig = trig[7];
    assign move      = (trig[TRIG_UP] ^ trig[TRIG_DOWN]) && (run_state == ST_RUN);
    assign event_hit = move && term && !trig[TRIG_CLEAR] && !trig[TRIG_LOAD];
    trig_counter_next #(.WIDTH(WIDTH), .STEP_W(STEP_W)) u_next (
        .count(count), .step(step), .limit(limit), .mode(mode), .up(trig[TRIG_UP]),
        .next_count(nxt), .term(term), .halt(halt)
    );
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            count      <= '0;
            snapshot   <= '0;
            term_pulse <= 1'b0;
            run_state  <= ST_RUN;
        end else begin
            term_pulse <= event_hit;
            if (trig[TRIG_SNAP]) snapshot <= 32'(count);
            if (trig[TRIG_CLEAR]) begin
                count     <= '0;
                run_state <= ST_RUN;
            end else if (trig[TRIG_LOAD]) begin
                count     <= (load_value > limit) ? limit : load_value;
                run_state <= ST_RUN;
            end else begin
                if (move) count <= nxt;
                if (move && halt) run_state <= ST_HALTED;
                else if (trig[TRIG_PAUSE] && !trig[TRIG_RESUME] && run_state == ST_RUN) run_state <= ST_PAUSED;
                else if (trig[TRIG_RESUME] && !trig[TRIG_PAUSE] && run_state == ST_PAUSED) run_state <= ST_RUN;
            end
        end
    end
    assign snap_lo = snapshot[15:0];
    assign snap_hi = snapshot[31:16];
`ifdef TRIG_UPDOWN_COUNTER_EVENT_CNT_EN
    always_ff @(posedge sys_clk) begin
        if (reset || trig[TRIG_CLEAR]) term_count <= '0;
        else if (event_hit && term_count != 16'hFFFF) term_count <= term_count + 16'd1;
    end
`else
    assign term_count = 16'h0000;
`endif
endmodule

// File: tb/tb_trig_updown_counter.sv
// tb_trig_updown_counter: directed scenarios plus randomized run against a behavioural model
module tb_trig_updown_counter;
    localparam logic [7:0] T_CLR = 8'h01, T_UP = 8'h02, T_DN = 8'h04, T_LD = 8'h08;
    localparam logic [7:0] T_SN = 8'h10, T_PA = 8'h20, T_RE = 8'h40;
`ifdef TRIG_UPDOWN_COUNTER_EVENT_CNT_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif
    logic        sys_clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  trig = '0;
    logic [31:0] load_value = '0;
    logic [15:0] step = '0;
    logic [31:0] limit = '0;
    logic [1:0]  mode = '0;
    logic [31:0] count;
    logic [15:0] snap_lo, snap_hi, term_count;
    logic        term_pulse;
    logic [1:0]  run_state;
    int n_cmp = 0;
    int n_bad = 0;
    longint m_count, m_snap;
    int m_state, m_tc;
    bit m_pulse;

    trig_updown_counter dut (
        .sys_clk(sys_clk), .reset(reset), .trig(trig), .load_value(load_value), .step(step),
        .limit(limit), .mode(mode), .count(count), .snap_lo(snap_lo), .snap_hi(snap_hi),
        .term_pulse(term_pulse), .run_state(run_state), .term_count(term_count)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic cyc(input logic [7:0] t, input logic r = 1'b0);
        @(negedge sys_clk);
        trig  = t;
        reset = r;
        @(posedge sys_clk);
        #1;
        trig  = '0;
        reset = 1'b0;
    endtask

    // Reference: state 0 = running, 1 = paused, 2 = halted
    task automatic model(input logic [7:0] t, input bit r);
        longint st, lim, lv;
        int ps;
        st  = (step == 0) ? 1 : longint'(step);
        lim = longint'(limit);
        lv  = longint'(load_value);
        ps  = m_state;
        m_pulse = 0;
        if (r) begin
            m_count = 0; m_snap = 0; m_state = 0; m_tc = 0;
            return;
        end
        if (t[4]) m_snap = m_count;
        if (t[0]) begin
            m_count = 0; m_state = 0; m_tc = 0;
        end else if (t[3]) begin
            m_count = (lv < lim) ? lv : lim;
            m_state = 0;
        end else begin
            if (t[1] != t[2] && ps == 0) begin
                if (t[1]) begin
                    if (m_count + st <= lim) m_count += st;
                    else begin m_pulse = 1; m_count = (mode == 1 || mode == 2) ? lim : 0; end
                end else begin
                    if (st <= m_count) m_count -= st;
                    else begin m_pulse = 1; m_count = (mode == 1 || mode == 2) ? 0 : lim; end
                end
                if (m_pulse && mode == 2) m_state = 2;
            end
            if (m_state != 2) begin
                if (t[5] && !t[6] && ps == 0) m_state = 1;
                else if (t[6] && !t[5] && ps == 1) m_state = 0;
            end
            if (m_pulse && EN && m_tc < 65535) m_tc++;
        end
    endtask

    task automatic test_reset;
        cyc(8'h00, 1'b1);
        cyc(8'h00, 1'b1);
        n_cmp++;
        if ({count, snap_hi, snap_lo, term_pulse, run_state, term_count} !== 83'd0) begin
            n_bad++;
            $display("FAIL reset: count=%h snap=%h_%h pulse=%b state=%b tc=%h, required all zero",
                     count, snap_hi, snap_lo, term_pulse, run_state, term_count);
        end
    endtask

    task automatic test_wrap_up;
        mode = 2'b00; limit = 9; step = 4; load_value = 8;
        cyc(T_LD);
        n_cmp++;
        if (count !== 32'd8) begin n_bad++; $display("FAIL wrap_load: count=%0d required 8", count); end
        cyc(T_UP);
        n_cmp++;
        if ({count, term_pulse} !== {32'd0, 1'b1}) begin
            n_bad++; $display("FAIL wrap_up: count=%0d pulse=%b required 0/1", count, term_pulse);
        end
        cyc(8'h00);
        n_cmp++;
        if ({count, term_pulse} !== {32'd0, 1'b0}) begin
            n_bad++; $display("FAIL wrap_pulse_len: count=%0d pulse=%b required 0/0", count, term_pulse);
        end
    endtask

    task automatic test_sat_down;
        mode = 2'b01; limit = 1000; step = 5; load_value = 3;
        cyc(T_LD);
        for (int i = 0; i < 2; i++) begin
            cyc(T_DN);
            n_cmp++;
            if ({count, term_pulse} !== {32'd0, 1'b1}) begin
                n_bad++; $display("FAIL sat_down%0d: count=%0d pulse=%b required 0/1", i, count, term_pulse);
            end
        end
    endtask

    task automatic test_oneshot;
        mode = 2'b10; limit = 100; step = 60;
        cyc(T_CLR);
        cyc(T_UP);
        n_cmp++;
        if ({count, term_pulse, run_state} !== {32'd60, 1'b0, 2'b00}) begin
            n_bad++; $display("FAIL oneshot_1: count=%0d pulse=%b state=%b required 60/0/00", count, term_pulse, run_state);
        end
        cyc(T_UP);
        n_cmp++;
        if ({count, term_pulse, run_state} !== {32'd100, 1'b1, 2'b10}) begin
            n_bad++; $display("FAIL oneshot_2: count=%0d pulse=%b state=%b required 100/1/10", count, term_pulse, run_state);
        end
        cyc(T_UP);
        n_cmp++;
        if ({count, term_pulse, run_state} !== {32'd100, 1'b0, 2'b10}) begin
            n_bad++; $display("FAIL oneshot_halted: count=%0d pulse=%b state=%b required 100/0/10", count, term_pulse, run_state);
        end
        load_value = 250;
        cyc(T_LD);
        n_cmp++;
        if ({count, run_state} !== {32'd100, 2'b00}) begin
            n_bad++; $display("FAIL oneshot_load: count=%0d state=%b required 100/00", count, run_state);
        end
    endtask

    task automatic test_priority;
        mode = 2'b00; limit = 1000; step = 1; load_value = 7;
        cyc(T_LD);
        cyc(T_CLR | T_LD | T_UP);
        n_cmp++;
        if (count !== 32'd0) begin n_bad++; $display("FAIL prio_clear: count=%0d required 0", count); end
        cyc(T_LD);
        cyc(T_UP | T_DN);
        n_cmp++;
        if ({count, term_pulse} !== {32'd7, 1'b0}) begin
            n_bad++; $display("FAIL prio_updown: count=%0d pulse=%b required 7/0", count, term_pulse);
        end
        cyc(T_PA | T_RE);
        n_cmp++;
        if (run_state !== 2'b00) begin n_bad++; $display("FAIL prio_pr_run: state=%b required 00", run_state); end
        cyc(T_PA);
        cyc(T_UP);
        n_cmp++;
        if ({count, run_state} !== {32'd7, 2'b01}) begin
            n_bad++; $display("FAIL paused_up: count=%0d state=%b required 7/01", count, run_state);
        end
        cyc(T_PA | T_RE);
        cyc(T_RE);
        cyc(T_UP);
        n_cmp++;
        if ({count, run_state} !== {32'd8, 2'b00}) begin
            n_bad++; $display("FAIL resume_up: count=%0d state=%b required 8/00", count, run_state);
        end
    endtask

    task automatic test_snapshot;
        mode = 2'b00; limit = 32'hFFFF_FFFF; step = 1; load_value = 32'h0001_FFFF;
        cyc(T_LD);
        cyc(T_SN | T_UP);
        n_cmp++;
        if ({snap_hi, snap_lo, count} !== {16'h0001, 16'hFFFF, 32'h0002_0000}) begin
            n_bad++; $display("FAIL snapshot: hi=%h lo=%h count=%h required 0001/ffff/00020000", snap_hi, snap_lo, count);
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] exp_tc;
        exp_tc = EN ? 16'd3 : 16'd0;
        cyc(T_CLR);
        mode = 2'b01; limit = 10; step = 1; load_value = 10;
        cyc(T_LD);
        for (int i = 0; i < 3; i++) cyc(T_UP);
        n_cmp++;
        if ({count, term_count} !== {32'd10, exp_tc}) begin
            n_bad++; $display("FAIL tally: count=%0d tc=%0d required 10/%0d", count, term_count, exp_tc);
        end
        limit = 100; load_value = 55;
        cyc(T_LD);
        cyc(T_PA);
        n_cmp++;
        if ({count, run_state, term_count} !== {32'd55, 2'b01, exp_tc}) begin
            n_bad++; $display("FAIL pre_reset: count=%0d state=%b tc=%0d required 55/01/%0d", count, run_state, term_count, exp_tc);
        end
        cyc(T_UP, 1'b1);
        n_cmp++;
        if ({count, snap_hi, snap_lo, term_pulse, run_state, term_count} !== 83'd0) begin
            n_bad++;
            $display("FAIL reset_mid: count=%h snap=%h_%h pulse=%b state=%b tc=%h, required all zero",
                     count, snap_hi, snap_lo, term_pulse, run_state, term_count);
        end
    endtask

    task automatic test_random;
        logic [7:0] t;
        bit r;
        int sel;
        cyc(8'h00, 1'b1);
        model(8'h00, 1'b1);
        limit = 20; mode = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom % 16 == 0) begin
                limit = $urandom_range(0, 40);
                mode  = 2'($urandom);
            end
            step       = 16'($urandom_range(0, 6));
            load_value = $urandom_range(0, 60);
            r   = ($urandom % 60) == 0;
            sel = $urandom % 8;
            t   = 8'($urandom & $urandom & $urandom);
            t  |= (sel < 3) ? T_UP : (sel < 5) ? T_DN : 8'h00;
            if ((t & (T_CLR | T_LD | T_UP | T_DN)) != 0 && ($urandom % 2 == 0)) t &= ~(T_PA | T_RE);
            if ((t & (T_UP | T_DN)) != 0 && mode == 2'b10) t &= ~(T_PA | T_RE);
            cyc(t, r);
            model(t, r);
            n_cmp++;
            if ({count, snap_hi, snap_lo, term_pulse, run_state, term_count} !==
                {m_count[31:0], m_snap[31:16], m_snap[15:0], m_pulse, 2'(m_state), 16'(m_tc)}) begin
                n_bad++;
                $display("FAIL random[%0d] trig=%h rst=%b: count=%0d snap=%h%h pulse=%b state=%b tc=%0d, required count=%0d snap=%h pulse=%b state=%0d tc=%0d",
                         i, t, r, count, snap_hi, snap_lo, term_pulse, run_state, term_count,
                         m_count, m_snap[31:0], m_pulse, m_state, m_tc);
            end
        end
    endtask

    initial begin
        test_reset;
        test_wrap_up;
        test_sat_down;
        test_oneshot;
        test_priority;
        test_snapshot;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
